// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the block-RAM port sharing logic: default geometry,
// requester id type and the response tag carried through the issue/return pipe.
package mem_ctrl_pkg;

  localparam int DWIDTH_DEF   = 16;
  localparam int AWIDTH_DEF   = 12;
  localparam int MEM_SIZE_DEF = 3840;

  // Identifies which of the two clients owns a request
  typedef logic req_id_t;

  // Travels alongside a request so its response can be steered back later
  typedef struct packed {
    logic    valid;
    req_id_t owner;
    logic    err;
  } rsp_tag_t;

  localparam rsp_tag_t TAG_EMPTY = '{valid: 1'b0, owner: 1'b0, err: 1'b0};

  function automatic rsp_tag_t make_tag(input logic valid, input req_id_t owner, input logic err);
    rsp_tag_t t;
    t.valid = valid;
    t.owner = owner;
    t.err   = err;
    return t;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Client-side bundle of both requesters: request channels with valid/ready and
// response channels without backpressure.
interface bram_port_arbiter_if #(
  parameter int DWIDTH = mem_ctrl_pkg::DWIDTH_DEF,
  parameter int AWIDTH = mem_ctrl_pkg::AWIDTH_DEF
);

  logic              req_valid0;
  logic              req_valid1;
  logic              req_ready0;
  logic              req_ready1;
  logic              req_we0;
  logic              req_we1;
  logic [AWIDTH-1:0] req_addr0;
  logic [AWIDTH-1:0] req_addr1;
  logic [DWIDTH-1:0] req_wdata0;
  logic [DWIDTH-1:0] req_wdata1;
  logic              rsp_valid0;
  logic              rsp_valid1;
  logic [DWIDTH-1:0] rsp_rdata0;
  logic [DWIDTH-1:0] rsp_rdata1;
  logic              rsp_err0;
  logic              rsp_err1;

  // Client side: issues requests, consumes grants and responses
  modport master (
    output req_valid0, req_valid1, req_we0, req_we1,
           req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready0, req_ready1,
           rsp_valid0, rsp_valid1, rsp_rdata0, rsp_rdata1, rsp_err0, rsp_err1
  );

  // Arbiter side: grants requests and produces responses
  modport slave (
    input  req_valid0, req_valid1, req_we0, req_we1,
           req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready0, req_ready1,
           rsp_valid0, rsp_valid1, rsp_rdata0, rsp_rdata1, rsp_err0, rsp_err1
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant from valid and a priority
// pointer that flips to the other requester after every handshake.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       fire,
  output req_id_t    grant_id
);

  req_id_t prio_reg;

  // Lone requester always wins; on contention the priority pointer decides
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio_reg ? 2'b10 : 2'b01;
    end
    fire     = |grant;
    grant_id = grant[1];
  end

  // After a handshake the other requester gets priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_reg <= 1'b0;
    end else if (fire) begin
      prio_reg <= ~grant_id;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one block-RAM port between two clients: round-robin grant, registered
// RAM drive, range check and a two-stage tag pipe that routes read data back.
module bram_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  bram_port_arbiter_if.slave req_bus,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q
);

  // One extra bit so a MEM_SIZE equal to 2**AWIDTH still compares correctly
  localparam logic [AWIDTH:0] ADDR_LIMIT = (AWIDTH + 1)'(MEM_SIZE);

  logic [1:0]        grant;
  logic              fire;
  req_id_t           grant_id;

  logic              sel_we;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;
  logic              sel_oor;
  logic              ram_access;

  rsp_tag_t          issue_tag_next;
  rsp_tag_t          issue_tag_reg;
  rsp_tag_t          ret_tag_reg;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid    ({req_bus.req_valid1, req_bus.req_valid0}),
    .grant    (grant),
    .fire     (fire),
    .grant_id (grant_id)
  );

  assign req_bus.req_ready0 = grant[0];
  assign req_bus.req_ready1 = grant[1];

  // Select the granted request and classify it
  always_comb begin
    sel_we    = grant_id ? req_bus.req_we1    : req_bus.req_we0;
    sel_addr  = grant_id ? req_bus.req_addr1  : req_bus.req_addr0;
    sel_wdata = grant_id ? req_bus.req_wdata1 : req_bus.req_wdata0;
    sel_oor   = {1'b0, sel_addr} >= ADDR_LIMIT;
    ram_access = fire & ~sel_oor;
    // Writes in range are silent; reads and every out-of-range access answer
    issue_tag_next = make_tag(fire & (~sel_we | sel_oor), grant_id, sel_oor);
  end

  // Register the RAM port drive; everything idles to zero without an access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_ce   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_d    <= '0;
    end else begin
      ram_ce   <= ram_access;
      ram_we   <= ram_access & sel_we;
      ram_addr <= ram_access ? sel_addr : '0;
      ram_d    <= (ram_access & sel_we) ? sel_wdata : '0;
    end
  end

  // Issue stage tracks the RAM cycle, return stage lines up with ram_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_tag_reg <= TAG_EMPTY;
      ret_tag_reg   <= TAG_EMPTY;
    end else begin
      issue_tag_reg <= issue_tag_next;
      ret_tag_reg   <= issue_tag_reg;
    end
  end

  // Steer the returning response to its owner; error responses carry zero data
  always_comb begin
    req_bus.rsp_valid0 = ret_tag_reg.valid & (ret_tag_reg.owner == 1'b0);
    req_bus.rsp_valid1 = ret_tag_reg.valid & (ret_tag_reg.owner == 1'b1);
    req_bus.rsp_err0   = req_bus.rsp_valid0 & ret_tag_reg.err;
    req_bus.rsp_err1   = req_bus.rsp_valid1 & ret_tag_reg.err;
    req_bus.rsp_rdata0 = (req_bus.rsp_valid0 & ~ret_tag_reg.err) ? ram_q : '0;
    req_bus.rsp_rdata1 = (req_bus.rsp_valid1 & ~ret_tag_reg.err) ? ram_q : '0;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed and random checks of bram_port_arbiter against a behavioural RAM
// and a handshake-level scoreboard.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ram_ce;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [15:0] ram_d;
  logic [15:0] ram_q = '0;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  bit rst_seen = 1'b0;

  typedef struct {
    int          due;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [15:0] mem [0:3839];
  logic [15:0] model_mem [0:4095];

  bram_port_arbiter_if #(.DWIDTH(16), .AWIDTH(12)) bus ();

  bram_port_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req_bus  (bus),
    .ram_ce   (ram_ce),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_d    (ram_d),
    .ram_q    (ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural RAM port 0: registered read, write on ce&we
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_d;
      else        ram_q <= mem[ram_addr];
    end
  end

  initial begin
    for (int i = 0; i < 3840; i++) mem[i] = 16'(i);
    for (int i = 0; i < 4096; i++) model_mem[i] = 16'(i);
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [11:0] a0, input logic [15:0] d0,
                       input logic v1, input logic w1, input logic [11:0] a1, input logic [15:0] d1);
    bus.req_valid0 = v0; bus.req_we0 = w0; bus.req_addr0 = a0; bus.req_wdata0 = d0;
    bus.req_valid1 = v1; bus.req_we1 = w1; bus.req_addr1 = a1; bus.req_wdata1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 12'd0, 16'd0, 1'b0, 1'b0, 12'd0, 16'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_value({tag, "_ce"},  ram_ce, 0);
    check_value({tag, "_we"},  ram_we, 0);
    check_value({tag, "_addr"}, ram_addr, 0);
    check_value({tag, "_d"},   ram_d, 0);
    check_value({tag, "_rv0"}, bus.rsp_valid0, 0);
    check_value({tag, "_rv1"}, bus.rsp_valid1, 0);
    check_value({tag, "_rd0"}, bus.rsp_rdata0, 0);
    check_value({tag, "_rd1"}, bus.rsp_rdata1, 0);
    check_value({tag, "_er0"}, bus.rsp_err0, 0);
    check_value({tag, "_er1"}, bus.rsp_err1, 0);
  endtask

  // Consume one observed response of requester r against its expectation queue
  task automatic handle_rsp(input int r, input logic v, input logic [15:0] d, input logic e);
    exp_t x;
    bit   have;
    have = (r == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (v) begin
      if (!have) begin
        check_value($sformatf("rsp_unexpected%0d", r), 1, 0);
      end else begin
        if (r == 0) x = q0.pop_front(); else x = q1.pop_front();
        check_value($sformatf("rsp_latency%0d", r), x.due, ncyc);
        check_value($sformatf("rsp_data%0d", r), d, x.data);
        check_value($sformatf("rsp_err%0d", r), e, x.err);
      end
    end else if (have) begin
      x = (r == 0) ? q0[0] : q1[0];
      if (x.due <= ncyc) begin
        check_value($sformatf("rsp_missing%0d", r), 0, 1);
        if (r == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  // Record an accepted request in the scoreboard and log it
  task automatic record_hs(input int r, input logic w, input logic [11:0] a, input logic [15:0] d);
    exp_t x;
    bit   oor;
    oor = (a >= 12'd3840);
    $display("txn n=%0d req=%0d %s addr=%0d wdata=%h%s", ncyc, r, w ? "wr" : "rd", a, d, oor ? " oor" : "");
    x.due = ncyc + 2;
    if (oor) begin
      x.err = 1'b1; x.data = 16'h0;
    end else if (w) begin
      model_mem[a] = d;
      return;
    end else begin
      x.err = 1'b0; x.data = model_mem[a];
    end
    if (r == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  always @(posedge reset) rst_seen = 1'b1;

  // Scoreboard monitor, sampling between rising edges
  always @(negedge clk) begin
    ncyc++;
    if (rst_seen) begin
      q0.delete();
      q1.delete();
      rst_seen = 1'b0;
    end
    if (!reset) begin
      handle_rsp(0, bus.rsp_valid0, bus.rsp_rdata0, bus.rsp_err0);
      handle_rsp(1, bus.rsp_valid1, bus.rsp_rdata1, bus.rsp_err1);
      check_value("one_ready", bus.req_ready0 & bus.req_ready1, 0);
      if (bus.req_valid0 && bus.req_ready0) record_hs(0, bus.req_we0, bus.req_addr0, bus.req_wdata0);
      if (bus.req_valid1 && bus.req_ready1) record_hs(1, bus.req_we1, bus.req_addr1, bus.req_wdata1);
    end
  end

  function automatic logic [11:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 12'($urandom_range(3830, 4095));
    return 12'($urandom_range(0, 15));
  endfunction

  initial begin
    logic acc0, acc1;
    int   issued;
    idle();
    #1 reset = 1'b1;
    #1 check_zero("por");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single writer: write then read addr 10
    next_cycle(); drive(1, 1, 12'd10, 16'hA5A5, 0, 0, 0, 0);
    @(negedge clk); check_value("sw_ready0", bus.req_ready0, 1);
    next_cycle(); drive(1, 0, 12'd10, 16'h0, 0, 0, 0, 0);
    @(negedge clk);
    check_value("sw_wr_ce", ram_ce, 1); check_value("sw_wr_we", ram_we, 1);
    check_value("sw_wr_addr", ram_addr, 10); check_value("sw_wr_d", ram_d, 16'hA5A5);
    check_value("sw_rv1_a", bus.rsp_valid1, 0);
    next_cycle(); idle();
    @(negedge clk);
    check_value("sw_rd_ce", ram_ce, 1); check_value("sw_rd_we", ram_we, 0);
    check_value("sw_rd_addr", ram_addr, 10);
    check_value("sw_rv0_early", bus.rsp_valid0, 0); check_value("sw_rv1_b", bus.rsp_valid1, 0);
    next_cycle();
    @(negedge clk);
    check_value("sw_rv0", bus.rsp_valid0, 1); check_value("sw_rd0", bus.rsp_rdata0, 16'hA5A5);
    check_value("sw_ce_off", ram_ce, 0); check_value("sw_rv1_c", bus.rsp_valid1, 0);

    // Reset with a read in flight
    next_cycle(); drive(1, 0, 12'd5, 16'h0, 0, 0, 0, 0);
    next_cycle(); idle();
    check_value("rst_pre_ce", ram_ce, 1);
    #1 reset = 1'b1;
    #1 check_zero("rst_async");
    #1 reset = 1'b0;
    @(negedge clk); check_value("rst_rv0_a", bus.rsp_valid0, 0);
    @(negedge clk); check_value("rst_rv0_b", bus.rsp_valid0, 0);

    // Contention: both read continuously, grants must start at requester 0
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if (k < 8) drive(1, 0, 12'd1, 16'h0, 1, 0, 12'd2, 16'h0);
      else idle();
      @(negedge clk);
      if (k < 8) begin
        check_value($sformatf("ct_ready0_k%0d", k), bus.req_ready0, (k % 2) == 0);
        check_value($sformatf("ct_ready1_k%0d", k), bus.req_ready1, (k % 2) == 1);
      end
      if (k >= 2) begin
        check_value($sformatf("ct_rv0_k%0d", k), bus.rsp_valid0, (k % 2) == 0);
        check_value($sformatf("ct_rv1_k%0d", k), bus.rsp_valid1, (k % 2) == 1);
        if ((k % 2) == 0) check_value($sformatf("ct_rd0_k%0d", k), bus.rsp_rdata0, 16'h0001);
        else              check_value($sformatf("ct_rd1_k%0d", k), bus.rsp_rdata1, 16'h0002);
      end
    end

    // Read-after-write across requesters at the top address
    next_cycle(); drive(0, 0, 0, 0, 1, 1, 12'd3839, 16'h1234);
    next_cycle(); drive(1, 0, 12'd3839, 16'h0, 0, 0, 0, 0);
    next_cycle(); idle();
    next_cycle();
    @(negedge clk);
    check_value("raw_rv0", bus.rsp_valid0, 1); check_value("raw_rd0", bus.rsp_rdata0, 16'h1234);
    check_value("raw_er0", bus.rsp_err0, 0);

    // Out of range from requester 1: write 3840, read 3840, read 4095
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      case (k)
        0: drive(0, 0, 0, 0, 1, 1, 12'd3840, 16'hBEEF);
        1: drive(0, 0, 0, 0, 1, 0, 12'd3840, 16'h0);
        2: drive(0, 0, 0, 0, 1, 0, 12'd4095, 16'h0);
        default: idle();
      endcase
      @(negedge clk);
      if (k >= 1 && k <= 3) check_value($sformatf("oor_ce_k%0d", k), ram_ce, 0);
      if (k >= 2) begin
        check_value($sformatf("oor_rv1_k%0d", k), bus.rsp_valid1, 1);
        check_value($sformatf("oor_er1_k%0d", k), bus.rsp_err1, 1);
        check_value($sformatf("oor_rd1_k%0d", k), bus.rsp_rdata1, 0);
        check_value($sformatf("oor_rv0_k%0d", k), bus.rsp_valid0, 0);
      end
    end

    // Random mixed traffic with valid gaps; valid holds until accepted
    next_cycle(); idle();
    acc0 = 1'b0; acc1 = 1'b0; issued = 0;
    for (int c = 0; c < 60000 && issued < 10000; c++) begin
      next_cycle();
      if (!bus.req_valid0 || acc0) begin
        bus.req_valid0 = ($urandom_range(0, 3) != 0);
        bus.req_we0 = 1'($urandom_range(0, 1));
        bus.req_addr0 = rand_addr();
        bus.req_wdata0 = 16'($urandom);
      end
      if (!bus.req_valid1 || acc1) begin
        bus.req_valid1 = ($urandom_range(0, 3) != 0);
        bus.req_we1 = 1'($urandom_range(0, 1));
        bus.req_addr1 = rand_addr();
        bus.req_wdata1 = 16'($urandom);
      end
      @(negedge clk);
      acc0 = bus.req_valid0 & bus.req_ready0;
      acc1 = bus.req_valid1 & bus.req_ready1;
      issued += int'(acc0) + int'(acc1);
    end
    check_value("rand_issued", issued >= 10000, 1);
    next_cycle(); idle();
    repeat (4) @(negedge clk);
    check_value("drain_q0", q0.size(), 0);
    check_value("drain_q1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
